// File: rtl/proc_pkg.sv
// Shared definitions for the processor front end: opcodes, instruction field
// positions and the fetch-stage state encoding.
package proc_pkg;

  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 29;
  localparam int REG1_HI = 28;
  localparam int REG1_LO = 24;
  localparam int REG2_HI = 23;
  localparam int REG2_LO = 19;
  localparam int REG3_HI = 18;
  localparam int REG3_LO = 16;
  localparam int ADDR_HI = 15;
  localparam int ADDR_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  function automatic logic [2:0] get_opcode(input logic [31:0] instWord);
    return instWord[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/inst_mem.sv
// Instruction RAM: independent write port and a registered read port whose
// output register is cleared by reset so the fetch output starts at zero.
module inst_mem #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [INST_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The read register only updates on a read, so the presented word holds
  // for as long as the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n)               rdata_q <= '0;
    else if (re_i && !we_i)   rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: walks the PC through the instruction RAM and presents one
// instruction at a time on a valid/ready handshake, with redirects and HALT.
module inst_fetch
  import proc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [INST_W-1:0] ld_data,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic [15:0]       count_q, count_d;
  logic [INST_W-1:0] rdata;
  logic              memWe, memRe, handshake, stopped;

  assign stopped   = (state_q == S_IDLE) || (state_q == S_HALT);
  assign handshake = (state_q == S_VALID) && inst_ready;
  assign memWe     = ld_en && stopped;
  assign memRe     = (state_q == S_REQ);

  inst_mem #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (memWe),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .re_i    (memRe),
    .raddr_i (pc_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  // Redirect wins over both the PC increment and the HALT transition, but an
  // instruction accepted in the same cycle is still counted.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d  = S_REQ;
          pc_d     = '0;
          count_d  = '0;
          halted_d = 1'b0;
        end
      end
      S_REQ: begin
        state_d = S_VALID;
        if (redirect_valid) begin
          state_d = S_REQ;
          pc_d    = redirect_pc;
        end
      end
      S_VALID: begin
        if (handshake && count_q != 16'hFFFF) count_d = count_q + 16'd1;
        if (redirect_valid) begin
          state_d = S_REQ;
          pc_d    = redirect_pc;
        end else if (handshake) begin
          if (rdata[INST_W-1 -: 3] == OP_HALT) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = S_REQ;
            pc_d    = pc_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign inst        = rdata;
  assign inst_valid  = (state_q == S_VALID);
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected (pc, inst) pairs are queued as
// stimulus is issued and a monitor checks them on every accepted instruction.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] fetch_count;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] inst;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  inst_fetch #(.ADDR_W(8), .INST_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .pc             (pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  // Monitor: every accepted instruction must match the oldest queued entry.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_unexpected: got pc=%h inst=%h expected no transfer", pc, inst);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sb_inst", inst, e.inst);
        checkOutput("sb_pc", {24'h0, pc}, {24'h0, e.pc});
      end
    end
  end

  initial begin
    int n;

    tick();
    tick();
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_valid", {31'h0, inst_valid}, 32'h0);
    checkOutput("rst_pc", {24'h0, pc}, 32'h0);
    checkOutput("rst_halted", {31'h0, halted}, 32'h0);
    checkOutput("rst_count", {16'h0, fetch_count}, 32'h0);
    rst_n = 1'b1;

    // Load and run to HALT with ready held high
    applyStimulus(8'h00, 32'h2000_0005);
    applyStimulus(8'h01, 32'h4100_0003);
    applyStimulus(8'h02, 32'hE000_0000);
    applyStimulus(8'h40, 32'hE000_0040);
    expQ.push_back('{pc: 8'h00, inst: 32'h2000_0005});
    expQ.push_back('{pc: 8'h01, inst: 32'h4100_0003});
    expQ.push_back('{pc: 8'h02, inst: 32'hE000_0000});
    start = 1'b1;
    inst_ready = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("run_req_valid", {31'h0, inst_valid}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("run_valid_hi", {31'h0, inst_valid}, 32'h1);
      tick();
      checkOutput("run_valid_lo", {31'h0, inst_valid}, 32'h0);
    end
    checkOutput("run_halted", {31'h0, halted}, 32'h1);
    checkOutput("run_count", {16'h0, fetch_count}, 32'd3);
    checkOutput("run_pc", {24'h0, pc}, 32'h2);
    inst_ready = 1'b0;

    // Backpressure, with ignored ld_en / start while presenting
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("restart_halted", {31'h0, halted}, 32'h0);
    checkOutput("restart_count", {16'h0, fetch_count}, 32'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      ld_en   = 1'b1;
      ld_addr = 8'h00;
      ld_data = 32'hFFFF_FFFF;
      start   = 1'b1;
      tick();
      checkOutput("bp_inst", inst, 32'h2000_0005);
      checkOutput("bp_pc", {24'h0, pc}, 32'h0);
      checkOutput("bp_valid", {31'h0, inst_valid}, 32'h1);
      checkOutput("bp_count", {16'h0, fetch_count}, 32'h0);
    end
    ld_en = 1'b0;
    start = 1'b0;
    expQ.push_back('{pc: 8'h00, inst: 32'h2000_0005});
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checkOutput("hs_valid_drop", {31'h0, inst_valid}, 32'h0);
    checkOutput("hs_count", {16'h0, fetch_count}, 32'h1);
    tick();
    checkOutput("pc1_pc", {24'h0, pc}, 32'h1);
    checkOutput("pc1_inst", inst, 32'h4100_0003);

    // Redirect while presenting PC 1
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    tick();
    redirect_valid = 1'b0;
    checkOutput("redir_valid_drop", {31'h0, inst_valid}, 32'h0);
    checkOutput("redir_pc", {24'h0, pc}, 32'h40);
    tick();
    checkOutput("redir_valid", {31'h0, inst_valid}, 32'h1);
    checkOutput("redir_inst", inst, 32'hE000_0040);
    expQ.push_back('{pc: 8'h40, inst: 32'hE000_0040});
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checkOutput("redir_halted", {31'h0, halted}, 32'h1);
    checkOutput("redir_count", {16'h0, fetch_count}, 32'd2);
    checkOutput("redir_halt_pc", {24'h0, pc}, 32'h40);

    // Re-run: address 0 must still hold the original word
    expQ.push_back('{pc: 8'h00, inst: 32'h2000_0005});
    expQ.push_back('{pc: 8'h01, inst: 32'h4100_0003});
    expQ.push_back('{pc: 8'h02, inst: 32'hE000_0000});
    start = 1'b1;
    inst_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!halted && n < 50) begin
      tick();
      n++;
    end
    inst_ready = 1'b0;
    checkOutput("rerun_halted", {31'h0, halted}, 32'h1);
    checkOutput("rerun_count", {16'h0, fetch_count}, 32'd3);

    // Wrap: 256 non-HALT words run end to end
    for (int a = 0; a < 256; a++) begin
      applyStimulus(8'(a), 32'h2000_0000 | 32'(a));
      expQ.push_back('{pc: 8'(a), inst: 32'h2000_0000 | 32'(a)});
    end
    start = 1'b1;
    inst_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (fetch_count != 16'd256 && n < 2000) begin
      tick();
      n++;
    end
    inst_ready = 1'b0;
    checkOutput("wrap_count", {16'h0, fetch_count}, 32'd256);
    checkOutput("wrap_pc", {24'h0, pc}, 32'h0);
    checkOutput("wrap_halted", {31'h0, halted}, 32'h0);

    // Reset while presenting an instruction
    tick();
    checkOutput("mid_valid", {31'h0, inst_valid}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("mrst_inst", inst, 32'h0);
    checkOutput("mrst_valid", {31'h0, inst_valid}, 32'h0);
    checkOutput("mrst_pc", {24'h0, pc}, 32'h0);
    checkOutput("mrst_count", {16'h0, fetch_count}, 32'h0);
    tick();
    checkOutput("mrst_idle", {31'h0, inst_valid}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("post_rst_valid", {31'h0, inst_valid}, 32'h1);
    checkOutput("post_rst_inst", inst, 32'h2000_0000);
    checkOutput("post_rst_pc", {24'h0, pc}, 32'h0);

    checkOutput("sb_drained", 32'(expQ.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly upstream of `processor`. Holds a 256-word instruction memory loaded through a side port, walks a program counter, and presents one 32-bit instruction at a time on a valid/ready handshake. It also accepts branch redirects from the execute side and stops on a HALT opcode.

## Interface
Parameters:
- `ADDR_W`, 8: PC / instruction-memory address width; depth is 2^ADDR_W.
- `INST_W`, 32: instruction width.

Ports:
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `ld_en` in 1: write strobe for the instruction memory. Honoured only in IDLE or HALT.
- `ld_addr` in ADDR_W: instruction-memory write address.
- `ld_data` in INST_W: instruction-memory write data.
- `start` in 1: begins fetching from PC 0. Honoured only in IDLE or HALT.
- `redirect_valid` in 1: branch taken; reload the PC.
- `redirect_pc` in ADDR_W: branch target.
- `inst` out INST_W: instruction presented to `processor`.
- `inst_valid` out 1: `inst` holds a valid instruction.
- `inst_ready` in 1: the consumer accepts `inst` this cycle.
- `pc` out ADDR_W: address of the instruction being fetched or presented.
- `halted` out 1: a HALT instruction has been accepted.
- `fetch_count` out 16: number of accepted instructions.

## Operation
- **States:** IDLE, REQ, VALID, HALT.
- **IDLE**
  - `ld_en` writes `imem[ld_addr] = ld_data`.
  - `start` does the following, then the block moves to REQ:
    - sets `pc` to 0
    - clears `fetch_count`
    - clears `halted`
- **REQ**
  - Synchronous read of `imem[pc]`.
  - Next state is VALID.
- **VALID**
  - `inst_valid` = 1 and `inst` = the registered read data.
  - `inst` and `pc` hold stable while `inst_ready` = 0.
- **Handshake** (`inst_valid & inst_ready` in VALID):
  - `fetch_count` increments, saturating at 0xFFFF.
  - If `inst[31:29]` == OP_HALT (3'b111): go to HALT, set `halted` = 1, `pc` unchanged.
  - Otherwise: `pc` <= `pc` + 1, wrapping modulo 2^ADDR_W (255 -> 0), and go to REQ.
- **Redirect** (`redirect_valid` in REQ or VALID):
  - `pc` <= `redirect_pc`, go to REQ, and `inst_valid` drops the next cycle.
  - Redirect overrides both the increment and the HALT transition.
  - If redirect and a handshake occur in the same cycle, the handshake still counts toward `fetch_count`.
- **Redirect in IDLE or HALT:** ignored.
- **HALT**
  - `inst_valid` = 0.
  - `ld_en` is honoured.
  - `start` restarts exactly as from IDLE.
- **`start` in REQ or VALID:** ignored.
- **`ld_en` in REQ or VALID:** ignored; memory contents are unchanged.

## Timing
- **Reset values** (applied at the rising edge with `rst_n` = 0):
  - state IDLE
  - `inst` = 0, `inst_valid` = 0
  - `pc` = 0
  - `halted` = 0
  - `fetch_count` = 0
- Instruction memory is not reset.
- **Reset mid-operation:** an in-flight fetch is discarded and the next cycle is IDLE with the reset values.
- **Latency:**
  - `start` sampled at edge t: REQ during cycle t+1, `inst_valid` = 1 from edge t+2.
  - Handshake at edge t: next `inst_valid` from edge t+2. Throughput is one instruction per 2 cycles when `inst_ready` is held high.
  - Redirect sampled at edge t: target instruction valid from edge t+2.
- **Load-to-fetch:** an `ld_en` write at edge t is visible to a `start` sampled at edge t (write happens before the REQ read at t+1).
- **Invariant:** `inst_valid` never deasserts without a handshake, redirect, or reset.

## Structure
- Shared package `proc_pkg`:
  - opcode constants OP_LW = 3'b001, OP_SW = 3'b010, OP_BEQ = 3'b011, OP_HALT = 3'b111
  - instruction field positions: opcode [31:29], reg1 [28:24], reg2 [23:19], reg3 [18:16], addr [15:0]
  - fetch state enum `fetch_state_t`
- Sub-module `inst_mem`:
  - single-port RAM with separate write port and synchronous read, parameterised by ADDR_W / INST_W
  - write has priority; reads are never issued in the same cycle as a write by construction
- Top level holds the FSM, PC, output register, and counter.

## Test plan
- **Load and run:** load 0x2000_0005 at 0, 0x4100_0003 at 1, and 0xE000_0000 at 2; `start`; `inst_ready` = 1. Expect:
  - `inst` sequence 0x2000_0005, 0x4100_0003, 0xE000_0000 with `inst_valid` at edges t+2, t+4, t+6
  - `halted` = 1 and `fetch_count` = 3
  - `pc` = 2
- **Backpressure:** `inst_ready` = 0 for 5 cycles while in VALID. Expect `inst`, `pc`, and `inst_valid` constant; no increment.
- **Redirect:** `redirect_valid` with `redirect_pc` = 0x40 while presenting PC 1. Expect `inst_valid` = 0 next cycle and `inst` = `imem[0x40]` two edges later.
- **Wrap:** a program with no HALT, started and run until PC 255 is accepted. Expect next `pc` = 0 and `fetch_count` = 256.
- **Ignored inputs:** `ld_en` writing 0xFFFF_FFFF to address 0 while in VALID. Expect a later fetch of address 0 returns the original word. `start` in VALID is also ignored.
- **Reset mid-run:** `rst_n` = 0 for one edge while in VALID. Expect all outputs at reset values and state IDLE. A subsequent `start` fetches the retained `imem[0]`.
